// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: time-multiplexed scan controller for a 4-digit
// seven-segment display fed through an external 4:1 nibble multiplexer.
//
// Ports:
//   clk         system clock
//   reset       synchronous, active-high reset
//   en          scan enable; 0 forces the display dark
//   digit_in    nibble returned by the external mux for the current sel
//   blank_mask  bit i=1 keeps digit i dark (sampled at frame start)
//   dp_mask     bit i=1 lights the decimal point of digit i (frame start)
//   sel         registered mux select / current digit index
//   an          anode enables, active low, bit i = digit i
//   seg         {g,f,e,d,c,b,a}, active low, registered
//   dp          decimal point, active low, registered
//   frame_tick  one-cycle pulse after each complete 4-digit frame
module disp_scan_ctrl #(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] digit_in,
    input  logic [3:0] blank_mask,
    input  logic [3:0] dp_mask,
    output logic [1:0] sel,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BLANK = 2'd1,
        S_SHOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] BLANK_LAST =
        CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST =
        CNT_W'(PRESCALE - BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       mask_q, mask_d;
    logic [3:0]       dpm_q, dpm_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             tick_q, tick_d;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        unique case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        dpm_d   = dpm_q;
        seg_d   = seg_q;
        dp_d    = dp_q;
        tick_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                idx_d = 2'd0;
                cnt_d = '0;
                seg_d = 7'h7F;
                dp_d  = 1'b1;
                if (en) begin
                    state_d = S_BLANK;
                end
            end
            S_BLANK: begin
                // First blank cycle of digit 0 is the frame boundary.
                if (idx_q == 2'd0 && cnt_q == '0) begin
                    mask_d = blank_mask;
                    dpm_d  = dp_mask;
                end
                if (cnt_q == BLANK_LAST) begin
                    // dpm_d so a one-cycle blank still sees this frame's mask
                    seg_d   = decode(digit_in);
                    dp_d    = ~dpm_d[idx_q];
                    state_d = S_SHOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    idx_d   = idx_q + 2'd1;
                    cnt_d   = '0;
                    state_d = S_BLANK;
                    tick_d  = (idx_q == 2'd3);
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 2'd0;
                cnt_d   = '0;
            end
        endcase

        // Dropping enable discards any partial frame.
        if (!en) begin
            state_d = S_IDLE;
            idx_d   = 2'd0;
            cnt_d   = '0;
            seg_d   = 7'h7F;
            dp_d    = 1'b1;
            tick_d  = 1'b0;
        end

        sel_d = idx_d;

        // Anodes derive from next state so they change with the digit.
        an_d = 4'hF;
        if (state_d == S_SHOW && !mask_d[idx_d]) begin
            an_d[idx_d] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= '0;
            mask_q  <= 4'h0;
            dpm_q   <= 4'h0;
            sel_q   <= 2'd0;
            an_q    <= 4'hF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            dpm_q   <= dpm_d;
            sel_q   <= sel_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            tick_q  <= tick_d;
        end
    end

    assign sel        = sel_q;
    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: directed bench for disp_scan_ctrl with
// PRESCALE=8, BLANK_CYCLES=2 and a behavioural 4:1 nibble mux.
module tb_disp_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [3:0] digit_in;
    logic [3:0] blank_mask;
    logic [3:0] dp_mask;
    logic [1:0] sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_tick;

    logic [3:0] m [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign digit_in = m[sel];

    disp_scan_ctrl #(
        .PRESCALE    (8),
        .BLANK_CYCLES(2),
        .CNT_W       (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .digit_in  (digit_in),
        .blank_mask(blank_mask),
        .dp_mask   (dp_mask),
        .sel       (sel),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .frame_tick(frame_tick)
    );

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[n];
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, "_an"}, {28'd0, an}, 32'hF);
        chk({tag, "_seg"}, {25'd0, seg}, 32'h7F);
        chk({tag, "_dp"}, {31'd0, dp}, 32'h1);
        chk({tag, "_sel"}, {30'd0, sel}, 32'h0);
        chk({tag, "_tick"}, {31'd0, frame_tick}, 32'h0);
    endtask

    // Checks one full frame starting at its first blank cycle.
    // At k=12 (digit 1 shown) the masks are changed to nbm/ndm.
    task automatic run_frame(input logic [3:0] bm,
                             input logic [3:0] dm,
                             input logic       t0,
                             input logic [3:0] nbm,
                             input logic [3:0] ndm);
        int         d;
        int         p;
        logic [3:0] ea;
        logic [1:0] es;
        logic       edp;
        logic       et;
        for (int k = 0; k < 32; k++) begin
            d  = k / 8;
            p  = k % 8;
            es = d[1:0];
            ea = 4'hF;
            if (p >= 2 && !bm[d]) ea[d] = 1'b0;
            et  = (k == 0) ? t0 : 1'b0;
            chk("an", {28'd0, an}, {28'd0, ea});
            chk("sel", {30'd0, sel}, {30'd0, es});
            chk("tick", {31'd0, frame_tick}, {31'd0, et});
            if (p >= 2) begin
                edp = ~dm[d];
                chk("seg", {25'd0, seg}, {25'd0, hex7(m[d])});
                chk("dp", {31'd0, dp}, {31'd0, edp});
            end
            if (k == 12) begin
                blank_mask = nbm;
                dp_mask    = ndm;
            end
            step();
        end
    endtask

    initial begin
        reset      = 1'b1;
        en         = 1'b1;
        blank_mask = 4'h0;
        dp_mask    = 4'h0;
        m[0] = 4'h1;
        m[1] = 4'h2;
        m[2] = 4'h3;
        m[3] = 4'h4;
        @(negedge clk);

        // reset held three cycles with en=1
        repeat (3) step();
        chk_dark("rst");
        reset = 1'b0;
        step();
        chk("start_an", {28'd0, an}, 32'hF);
        chk("start_sel", {30'd0, sel}, 32'h0);

        // plain scan order
        run_frame(4'h0, 4'h0, 1'b0, 4'h0, 4'h0);

        // frame-boundary masks; blank_mask cleared mid-frame
        blank_mask = 4'b1000;
        dp_mask    = 4'b0001;
        run_frame(4'b1000, 4'b0001, 1'b1, 4'b0000, 4'b0001);
        run_frame(4'b0000, 4'b0001, 1'b1, 4'b0000, 4'b0000);
        run_frame(4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000);

        // digit_in only sampled on the last blank cycle
        m[0] = 4'hF;
        chk("t5_tick", {31'd0, frame_tick}, 32'h1);
        repeat (2) step();
        chk("t5_segF", {25'd0, seg}, 32'h0E);
        repeat (2) step();
        m[0] = 4'h8;
        for (int i = 0; i < 5; i++) begin
            chk("t5_hold", {25'd0, seg}, 32'h0E);
            step();
        end
        repeat (23) step();
        repeat (2) step();
        chk("t5_seg8", {25'd0, seg}, 32'h00);
        m[0] = 4'h1;

        // enable drop during digit 2 shown
        repeat (18) step();
        chk("t4_an2", {28'd0, an}, 32'hB);
        en = 1'b0;
        step();
        chk_dark("en0");
        repeat (2) step();
        chk_dark("en0b");
        en = 1'b1;
        step();
        run_frame(4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
        run_frame(4'h0, 4'h0, 1'b1, 4'h0, 4'h0);

        // reset mid-frame with en=1
        blank_mask = 4'b0010;
        chk("t6_tick", {31'd0, frame_tick}, 32'h1);
        repeat (10) step();
        chk("t6_masked", {28'd0, an}, 32'hF);
        chk("t6_sel", {30'd0, sel}, 32'h1);
        blank_mask = 4'h0;
        reset = 1'b1;
        step();
        chk_dark("rst2");
        step();
        chk_dark("rst2b");
        reset = 1'b0;
        step();
        run_frame(4'h0, 4'h0, 1'b0, 4'h0, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
